sqrt8_rem_stage: RTL

Registered consumer for the 8-bit combinational integer square-root stage. It captures each operand `x` and its 4-bit root `q` through a valid/ready handshake and computes `q*q` with an iterative shift-add multiplier. It then produces the remainder `r = x - q*q` and flags roots that fail the check `q*q <= x < (q+1)*(q+1)`. Results are held until the downstream sink accepts them.

---
 rtl/sqrt8_rem_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sqrt8_rem_stage.sv
// sqrt8_rem_stage
//   Registered consumer for an 8-bit integer square-root stage. It accepts
//   a radicand x and a candidate 4-bit root q. It forms q*q with a 4-cycle
//   shift-add multiplier, then derives the remainder x - q*q. The root is
//   flagged as wrong unless q*q <= x < (q+1)*(q+1). The result is held
//   until the sink takes it.
//
// Parameters
//   CHECK_EN   1: out_err reports a bad root and out_r is 0 for bad roots.
//              0: out_err is 0 and out_r is the raw low 5 bits of x - q*q.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream offers in_x / in_q
//   in_ready   stage is idle and will take the operand
//   in_x       radicand (8 bits)
//   in_q       root under test (4 bits)
//   out_valid  a result is held on out_q / out_r / out_err
//   out_ready  sink takes the held result
//   out_q      captured root
//   out_r      remainder, 0..30
//   out_err    root failed the range check
module sqrt8_rem_stage #(
    parameter int CHECK_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [3:0] in_q,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_q,
    output logic [4:0] out_r,
    output logic       out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        x_reg;
    logic [3:0]        q_reg;
    logic [7:0]        acc;
    logic [1:0]        cnt;
    logic signed [8:0] d_chk;
    logic              err_chk;
    logic [4:0]        r_chk;

    // 9-bit signed difference; the extra bit keeps q*q > x visible as negative.
    function automatic logic signed [8:0] diff9(input logic [7:0] a,
                                                input logic [7:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // A correct root leaves 0 <= x - q*q <= 2q, since (q+1)^2 - q^2 = 2q + 1.
    function automatic logic root_bad(input logic signed [8:0] d,
                                      input logic [3:0]        q);
        logic signed [8:0] lim;
        lim = $signed({4'b0000, q, 1'b0});
        return (d < 9'sd0) || (d > lim);
    endfunction

    // Bad roots report a zero remainder so the sink never sees garbage.
    function automatic logic [4:0] rem_sel(input logic signed [8:0] d,
                                           input logic              bad);
        return bad ? 5'd0 : d[4:0];
    endfunction

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = MUL;
            MUL:     if (cnt == 2'd3)  state_nxt = CHECK;
            CHECK:                     state_nxt = HOLD;
            HOLD:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        d_chk = diff9(x_reg, acc);
        if (CHECK_EN != 0) begin
            err_chk = root_bad(d_chk, q_reg);
            r_chk   = rem_sel(d_chk, err_chk);
        end else begin
            err_chk = 1'b0;
            r_chk   = d_chk[4:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= 8'd0;
            q_reg     <= 4'd0;
            acc       <= 8'd0;
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            out_q     <= 4'd0;
            out_r     <= 5'd0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                // capture stage: operands are only ever sampled here
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_x;
                        q_reg <= in_q;
                        acc   <= 8'd0;
                        cnt   <= 2'd0;
                    end
                end
                // multiply stage: one partial product per cycle, LSB first
                MUL: begin
                    if (q_reg[cnt]) begin
                        acc <= acc + ({4'b0000, q_reg} << cnt);
                    end
                    cnt <= cnt + 2'd1;
                end
                // check stage: register the verdict and raise out_valid
                CHECK: begin
                    out_q     <= q_reg;
                    out_r     <= r_chk;
                    out_err   <= err_chk;
                    out_valid <= 1'b1;
                end
                // hold stage: outputs frozen until the sink accepts
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
